ps2_key_encoder: RTL and testbench
==================================

Name: ps2_key_encoder

Overview:
- Converts the raw PS/2 keyboard serial stream (device-driven clock/data lines) into the 11-bit toggle-strobe key word consumed by core key handlers: {strobe toggle, pressed, extended, scan code}.
- Sits between the physical or user-port PS/2 pins and any clk_sys key decoder; it is the producing end of the ps2_key interface.
- Handles line sync, glitch filtering, frame checking, E0/F0 prefixes, E1 pause-sequence suppression and stalled-frame timeout.

Parameters:
FILTER, 8, clk_sys cycles a synced PS/2 clock level must stay stable before it is accepted (1..255)
TIMEOUT, 12000, clk_sys cycles without an accepted falling edge mid-frame before the frame is aborted (~1 ms at 12 MHz)

Ports:
clk_sys  input  1  system clock; the only clock
reset  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock line, asynchronous
ps2_data  input  1  raw PS/2 data line, asynchronous
ps2_key  output  11  [10] toggles once per decoded key event; [9] 1=make, 0=break; [8] E0-extended; [7:0] scan code
frame_err  output  1  one-cycle pulse on a rejected frame (start/parity/stop error or timeout)

Behaviour:
- Reset values: ps2_key=11'h000, frame_err=0, state IDLE, ext/brk flags 0, skip counter 0, bit counter 0, filter output 1.
- Input sync: two-flop synchronizer on each of ps2_clk and ps2_data.
- Clock filter: the filtered clock changes only after the synced clock differs from it for FILTER consecutive cycles. A falling edge of the filtered clock is a "sample event". The data sample is the synced ps2_data on that cycle.
- State machine (one transition per sample event):
  - IDLE: data=0 -> DATA with bit counter 0. Data=1 -> stay in IDLE; this is not an error.
  - DATA: shift the sample in LSB-first. After the 8th bit -> PARITY.
  - PARITY: store the sample -> STOP.
  - STOP: frame valid iff the sample is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). Return to IDLE in all cases.
- Invalid frame: frame_err=1 for one cycle. Byte discarded. ext/brk flags and skip counter cleared. ps2_key unchanged.
- Timeout:
  - A timer clears on every sample event and counts while state is not IDLE.
  - Reaching TIMEOUT -> IDLE, frame_err pulse, flags cleared.
  - The timer never runs in IDLE.
- Valid byte, evaluated on the cycle after STOP, in this priority order:
  - skip counter nonzero: decrement it, discard the byte.
  - 8'hE1: skip counter=7 (Pause sequence suppressed), discard.
  - 8'hE0: ext=1.
  - 8'hF0: brk=1.
  - Any other code: ps2_key <= {~ps2_key[10], ~brk, ext, byte}; then clear ext and brk.
- Latency: ps2_key updates exactly 2 clk_sys cycles after the sample event that captures the stop bit (1 cycle to validate, 1 cycle to register).
- frame_err is asserted on the cycle after the offending stop-bit sample event, or on the cycle after the timer reaches TIMEOUT.
- Only ps2_key[10] carries event meaning. Consumers detect a change of bit 10. Identical consecutive events still toggle bit 10.
- Prefix order E0 F0 xx and F0 alone are both supported. A repeated prefix is idempotent.
- Reset asserted mid-frame: next cycle is the reset state; partial bits are lost. The first frame after deassertion must begin with a fresh start bit.
- Lines held low indefinitely: at most one timeout error per stalled frame; no further errors until a new start bit.

Test Plan:
- Frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) from reset -> ps2_key=11'h61C exactly 2 cycles after the stop sample; frame_err stays 0.
- Frames F0 (parity 1), then 1C -> ps2_key 11'h61C -> 11'h01C; no ps2_key change after the F0 frame alone.
- Frames E0, 75 (parity 0 each) after the previous test -> ps2_key=11'h775; a following E0,F0,75 sequence -> 11'h175.
- Frame 0x29 with parity bit 1 -> frame_err single-cycle pulse, ps2_key unchanged. A following valid 0x29 -> bit 10 toggled, [9:0]=10'h229.
- Start bit plus 5 data bits, then lines idle high -> frame_err after TIMEOUT cycles. Next valid 0x1C decodes normally.
- Sequence E1 14 77 E1 F0 14 F0 77 -> no ps2_key change. Next frame 0x16 -> [9:0]=10'h216. A 3-cycle glitch low on ps2_clk (FILTER=8) is ignored. Reset asserted mid-frame -> ps2_key=0 next cycle.

Source files
------------

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: turns the raw device-clocked serial stream into the
// 11-bit toggle-strobe key word {toggle, pressed, extended, scan code}.
module ps2_key_encoder #(
   parameter int unsigned FILTER  = 8,
   parameter int unsigned TIMEOUT = 12000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        frame_err
);

   localparam int unsigned FCNT_W = 8;
   localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned BCNT_W = 3;
   localparam int unsigned SKIP_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   logic              clk_meta, clk_sync, dat_meta, dat_sync;
   logic              clk_filt;
   logic [FCNT_W-1:0] filt_cnt;
   logic              sample_evt;

   state_t              state_q, state_d;
   logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [7:0]          shreg_q, shreg_d;
   logic                par_q, par_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic                byte_vld_q, byte_vld_d;
   logic                ext_q, ext_d, brk_q, brk_d;
   logic [SKIP_W-1:0]   skip_q, skip_d;
   logic [10:0]         key_d;
   logic                err_d;
   logic                frame_bad;

   // Two-flop synchronizers plus stability filter on the PS/2 clock
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else begin
         clk_meta <= ps2_clk;
         clk_sync <= clk_meta;
         dat_meta <= ps2_data;
         dat_sync <= dat_meta;
         if (clk_sync != clk_filt) begin
            if (filt_cnt == FCNT_W'(FILTER - 1)) begin
               clk_filt <= clk_sync;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + FCNT_W'(1);
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   // Sample event: the cycle on which the filter accepts a falling edge
   assign sample_evt = clk_filt & ~clk_sync & (filt_cnt == FCNT_W'(FILTER - 1));

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         par_q      <= 1'b0;
         timer_q    <= '0;
         byte_vld_q <= 1'b0;
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         skip_q     <= '0;
         ps2_key    <= '0;
         frame_err  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         par_q      <= par_d;
         timer_q    <= timer_d;
         byte_vld_q <= byte_vld_d;
         ext_q      <= ext_d;
         brk_q      <= brk_d;
         skip_q     <= skip_d;
         ps2_key    <= key_d;
         frame_err  <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      par_d      = par_q;
      timer_d    = timer_q;
      byte_vld_d = 1'b0;
      ext_d      = ext_q;
      brk_d      = brk_q;
      skip_d     = skip_q;
      key_d      = ps2_key;
      err_d      = 1'b0;
      frame_bad  = 1'b0;

      // Stall timer only runs inside a frame
      if ((state_q == IDLE) || sample_evt) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TMR_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (sample_evt && !dat_sync) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (sample_evt) begin
               shreg_d   = {dat_sync, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + BCNT_W'(1);
               if (bit_cnt_q == BCNT_W'(7)) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (sample_evt) begin
               par_d   = dat_sync;
               state_d = STOP;
            end
         end
         STOP: begin
            if (sample_evt) begin
               state_d = IDLE;
               if (dat_sync && (^{shreg_q, par_q})) begin
                  byte_vld_d = 1'b1;
               end else begin
                  frame_bad = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if ((state_q != IDLE) && !sample_evt && (timer_q == TMR_W'(TIMEOUT - 1))) begin
         state_d   = IDLE;
         timer_d   = '0;
         frame_bad = 1'b1;
      end

      // Byte decode one cycle after a good stop bit; shreg holds the byte
      if (byte_vld_q) begin
         if (skip_q != '0) begin
            skip_d = skip_q - SKIP_W'(1);
         end else if (shreg_q == 8'hE1) begin
            skip_d = SKIP_W'(7);
         end else if (shreg_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (shreg_q == 8'hF0) begin
            brk_d = 1'b1;
         end else begin
            key_d = {~ps2_key[10], ~brk_q, ext_q, shreg_q};
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end

      if (frame_bad) begin
         err_d  = 1'b1;
         ext_d  = 1'b0;
         brk_d  = 1'b0;
         skip_d = '0;
      end
   end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Bench for ps2_key_encoder: directed vector table, timeout/reset/glitch
// sequences and random frames against a byte-level reference model.
module tb_ps2_key_encoder;

   localparam int unsigned FILTER  = 8;
   localparam int unsigned TIMEOUT = 1000;
   localparam int          HP      = 30;

   logic        clk_sys  = 1'b0;
   logic        reset    = 1'b1;
   logic        ps2_clk  = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        frame_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int stop_cyc = 0;
   int key_chg_cyc = 0;
   int err_seen = 0;
   int err_run = 0;
   logic [10:0] last_key = '0;

   // reference model state
   int          m_skip = 0;
   bit          m_ext = 0, m_brk = 0;
   logic [10:0] m_key = '0;

   ps2_key_encoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .ps2_key  (ps2_key),
      .frame_err(frame_err)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Output monitor: key-change timestamps and frame_err pulse widths
   always @(negedge clk_sys) begin
      if (ps2_key !== last_key) begin
         last_key    = ps2_key;
         key_chg_cyc = cyc;
      end
      if (frame_err === 1'b1) begin
         if (err_run == 0) err_seen++;
         err_run++;
      end else if (err_run != 0) begin
         check("err_width", err_run, 1);
         err_run = 0;
      end
   end

   task automatic model_frame(input logic [7:0] b, input bit ok);
      if (!ok) begin
         m_ext = 0; m_brk = 0; m_skip = 0;
      end else if (m_skip > 0) begin
         m_skip--;
      end else if (b == 8'hE1) begin
         m_skip = 7;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         m_key = {~m_key[10], ~m_brk, m_ext, b};
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic send_bit(input logic v, input bit glitch);
      ps2_data = v;
      if (glitch) begin
         repeat (18) @(negedge clk_sys);
         ps2_clk = 1'b0;
         repeat (3) @(negedge clk_sys);
         ps2_clk = 1'b1;
         repeat (HP - 21) @(negedge clk_sys);
      end else begin
         repeat (HP) @(negedge clk_sys);
      end
      ps2_clk  = 1'b0;
      stop_cyc = cyc;
      repeat (HP) @(negedge clk_sys);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad, input bit glitch);
      logic p;
      p = ~(^b) ^ bad;
      send_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
      send_bit(p, glitch);
      send_bit(1'b1, glitch);
      ps2_data = 1'b1;
      repeat (10) @(negedge clk_sys);
   endtask

   typedef struct {
      logic [7:0]  code;
      bit          bad;
      bit          glitch;
      logic [10:0] exp_key;
      int          exp_err;
   } vec_t;

   vec_t vecs[20];

   initial begin
      int e0, lat, r;
      logic [10:0] prev_exp;
      logic [7:0]  b;
      bit          bad;

      vecs[0]  = '{8'h1C, 0, 0, 11'h61C, 0};
      vecs[1]  = '{8'hF0, 0, 0, 11'h61C, 0};
      vecs[2]  = '{8'h1C, 0, 0, 11'h01C, 0};
      vecs[3]  = '{8'hE0, 0, 0, 11'h01C, 0};
      vecs[4]  = '{8'h75, 0, 0, 11'h775, 0};
      vecs[5]  = '{8'hE0, 0, 0, 11'h775, 0};
      vecs[6]  = '{8'hF0, 0, 0, 11'h775, 0};
      vecs[7]  = '{8'h75, 0, 0, 11'h175, 0};
      vecs[8]  = '{8'h29, 1, 0, 11'h175, 1};
      vecs[9]  = '{8'h29, 0, 0, 11'h629, 0};
      vecs[10] = '{8'hE1, 0, 0, 11'h629, 0};
      vecs[11] = '{8'h14, 0, 0, 11'h629, 0};
      vecs[12] = '{8'h77, 0, 0, 11'h629, 0};
      vecs[13] = '{8'hE1, 0, 0, 11'h629, 0};
      vecs[14] = '{8'hF0, 0, 0, 11'h629, 0};
      vecs[15] = '{8'h14, 0, 0, 11'h629, 0};
      vecs[16] = '{8'hF0, 0, 0, 11'h629, 0};
      vecs[17] = '{8'h77, 0, 0, 11'h629, 0};
      vecs[18] = '{8'h16, 0, 0, 11'h216, 0};
      vecs[19] = '{8'h1C, 0, 1, 11'h61C, 0};

      reset = 1'b1;
      repeat (5) @(negedge clk_sys);
      check("reset_key", ps2_key, 11'h000);
      check("reset_err", frame_err, 0);
      reset = 1'b0;
      repeat (20) @(negedge clk_sys);

      prev_exp = 11'h000;
      for (int i = 0; i < 20; i++) begin
         e0 = err_seen;
         send_frame(vecs[i].code, vecs[i].bad, vecs[i].glitch);
         model_frame(vecs[i].code, !vecs[i].bad);
         check("vec_key", ps2_key, vecs[i].exp_key);
         check("vec_err", err_seen - e0, vecs[i].exp_err);
         if (vecs[i].exp_key != prev_exp) begin
            lat = key_chg_cyc - stop_cyc;
            check("vec_latency", int'(lat >= FILTER + 2 && lat <= FILTER + 4), 1);
         end
         prev_exp = vecs[i].exp_key;
      end

      // Stalled frame: start bit plus 5 data bits, then lines idle high
      e0 = err_seen;
      send_bit(1'b0, 0);
      for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 0);
      ps2_data = 1'b1;
      repeat (TIMEOUT + 60) @(negedge clk_sys);
      check("timeout_err", err_seen - e0, 1);
      model_frame(8'h00, 0);
      repeat (2 * TIMEOUT) @(negedge clk_sys);
      check("timeout_once", err_seen - e0, 1);
      check("timeout_key", ps2_key, m_key);
      send_frame(8'h1C, 0, 0);
      model_frame(8'h1C, 1);
      check("after_timeout_key", ps2_key, m_key);
      check("after_timeout_err", err_seen - e0, 1);

      // Reset mid-frame
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      reset = 1'b1;
      @(negedge clk_sys);
      check("midreset_key", ps2_key, 11'h000);
      check("midreset_err", frame_err, 0);
      reset = 1'b0;
      m_key = '0; m_ext = 0; m_brk = 0; m_skip = 0;
      repeat (20) @(negedge clk_sys);
      e0 = err_seen;
      send_frame(8'h1C, 0, 0);
      model_frame(8'h1C, 1);
      check("post_reset_key", ps2_key, 11'h61C);
      check("post_reset_err", err_seen - e0, 0);

      // Random frames against the model
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0:       b = 8'hE0;
            1:       b = 8'hF0;
            2:       b = 8'hE1;
            default: b = 8'($urandom_range(0, 255));
         endcase
         bad = ($urandom_range(0, 7) == 0);
         e0 = err_seen;
         send_frame(b, bad, ($urandom_range(0, 5) == 0));
         model_frame(b, !bad);
         check("rand_key", ps2_key, m_key);
         check("rand_err", err_seen - e0, int'(bad));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
